// File: rtl/lstm_gate_data_buffer.sv
// Pairs weight/input words with bias words, tags them with unit/gate indices and
// queues the packets in a first-word fall-through FIFO for the gate MAC stage.
module lstm_gate_data_buffer #(
  parameter int W_BITWIDTH  = 8,
  parameter int IN_BITWIDTH = 8,
  parameter int B_BITWIDTH  = 32,
  parameter int N_GATES     = 4,
  parameter int NO_UNITS    = 2,
  parameter int SIZE_BUFFER = 10,
  localparam int UW = (NO_UNITS > 1) ? $clog2(NO_UNITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    wr_valid_i,
  input  logic                    wr_is_bias_i,
  input  logic [31:0]             wr_data_i,
  output logic                    wr_ready_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [3*W_BITWIDTH-1:0] out_weight_o,
  output logic [IN_BITWIDTH-1:0]  out_input_o,
  output logic [B_BITWIDTH-1:0]   out_bias_o,
  output logic [1:0]              out_gate_o,
  output logic [UW-1:0]           out_unit_o,
  output logic                    out_last_o,
  output logic                    load_done_o,
  output logic                    err_o
);

  localparam int WW = 3 * W_BITWIDTH;
  localparam int HW = WW + IN_BITWIDTH;
  localparam int PW = (SIZE_BUFFER > 1) ? $clog2(SIZE_BUFFER) : 1;
  localparam int CW = $clog2(SIZE_BUFFER + 1);
  localparam int EW = HW + B_BITWIDTH + 2 + UW + 1;

  localparam logic [1:0]    GATE_MAX = 2'(N_GATES - 1);
  localparam logic [UW-1:0] UNIT_MAX = UW'(NO_UNITS - 1);
  localparam logic [PW-1:0] PTR_MAX  = PW'(SIZE_BUFFER - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(SIZE_BUFFER);

  typedef enum logic {S_WAIT_WI, S_WAIT_B} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    gate_q, gate_d;
  logic [UW-1:0] unit_q, unit_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          load_done_q, load_done_d;
  logic          err_q, err_d;

  logic [EW-1:0] fifo_mem [SIZE_BUFFER];
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head_entry;
  logic          accept, push, pop, full, last_tag, mem_we;

  always_comb begin
    full        = (count_q == CNT_FULL);
    out_valid_o = (count_q != '0);
    wr_ready_o  = (state_q == S_WAIT_WI) ? !load_done_q : !full;
    accept      = wr_valid_i & wr_ready_o;
    push        = accept & wr_is_bias_i & (state_q == S_WAIT_B);
    pop         = out_valid_o & out_ready_i;
    last_tag    = (gate_q == GATE_MAX) && (unit_q == UNIT_MAX);
    push_entry  = {hold_q, wr_data_i[B_BITWIDTH-1:0], gate_q, unit_q, last_tag};
    mem_we      = push & !clear_i;

    state_d     = state_q;
    hold_d      = hold_q;
    gate_d      = gate_q;
    unit_d      = unit_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    load_done_d = load_done_q;
    err_d       = err_q;

    if (accept) begin
      if (state_q == S_WAIT_WI) begin
        if (wr_is_bias_i) begin
          err_d = 1'b1;
        end else begin
          hold_d  = wr_data_i[HW-1:0];
          state_d = S_WAIT_B;
        end
      end else begin
        if (wr_is_bias_i) begin
          state_d = S_WAIT_WI;
        end else begin
          hold_d = wr_data_i[HW-1:0];
          err_d  = 1'b1;
        end
      end
    end

    // Unit index advances only when the gate index wraps around.
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PW'(1);
      if (gate_q == GATE_MAX) begin
        gate_d = '0;
        unit_d = (unit_q == UNIT_MAX) ? '0 : unit_q + UW'(1);
      end else begin
        gate_d = gate_q + 2'd1;
      end
      if (last_tag) load_done_d = 1'b1;
    end

    if (pop) rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (clear_i) begin
      state_d     = S_WAIT_WI;
      hold_d      = '0;
      gate_d      = '0;
      unit_d      = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      load_done_d = 1'b0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q     <= S_WAIT_WI;
      hold_q      <= '0;
      gate_q      <= '0;
      unit_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      gate_q      <= gate_d;
      unit_q      <= unit_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
    end
  end

  // Storage is not reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (mem_we && !rst_i) fifo_mem[wr_ptr_q] <= push_entry;
  end

  always_comb begin
    head_entry = out_valid_o ? fifo_mem[rd_ptr_q] : '0;
    {out_input_o, out_weight_o, out_bias_o, out_gate_o, out_unit_o, out_last_o} = head_entry;
    load_done_o = load_done_q;
    err_o       = err_q;
  end

endmodule

// File: tb/tb_lstm_gate_data_buffer.sv
// Directed bench for lstm_gate_data_buffer: one default instance plus a
// three-unit instance (shared stimulus) used to fill the FIFO without load-done.
module tb_lstm_gate_data_buffer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        wr_valid_i = 1'b0;
  logic        wr_is_bias_i = 1'b0;
  logic [31:0] wr_data_i = '0;
  logic        out_ready_i = 1'b0;

  logic        wr_ready_o, out_valid_o, out_last_o, load_done_o, err_o;
  logic [23:0] out_weight_o;
  logic [7:0]  out_input_o;
  logic [31:0] out_bias_o;
  logic [1:0]  out_gate_o;
  logic [0:0]  out_unit_o;

  logic        b_wr_ready_o, b_out_valid_o, b_out_last_o, b_load_done_o, b_err_o;
  logic [23:0] b_out_weight_o;
  logic [7:0]  b_out_input_o;
  logic [31:0] b_out_bias_o;
  logic [1:0]  b_out_gate_o;
  logic [1:0]  b_out_unit_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lstm_gate_data_buffer dut (
    .clk(clk), .rst_i(rst_i), .clear_i(clear_i),
    .wr_valid_i(wr_valid_i), .wr_is_bias_i(wr_is_bias_i), .wr_data_i(wr_data_i),
    .wr_ready_o(wr_ready_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_weight_o(out_weight_o), .out_input_o(out_input_o), .out_bias_o(out_bias_o),
    .out_gate_o(out_gate_o), .out_unit_o(out_unit_o), .out_last_o(out_last_o),
    .load_done_o(load_done_o), .err_o(err_o)
  );

  lstm_gate_data_buffer #(.NO_UNITS(3)) dut3 (
    .clk(clk), .rst_i(rst_i), .clear_i(clear_i),
    .wr_valid_i(wr_valid_i), .wr_is_bias_i(wr_is_bias_i), .wr_data_i(wr_data_i),
    .wr_ready_o(b_wr_ready_o), .out_valid_o(b_out_valid_o), .out_ready_i(out_ready_i),
    .out_weight_o(b_out_weight_o), .out_input_o(b_out_input_o), .out_bias_o(b_out_bias_o),
    .out_gate_o(b_out_gate_o), .out_unit_o(b_out_unit_o), .out_last_o(b_out_last_o),
    .load_done_o(b_load_done_o), .err_o(b_err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic is_bias, input logic [31:0] data);
    wr_valid_i   = 1'b1;
    wr_is_bias_i = is_bias;
    wr_data_i    = data;
    tick();
    wr_valid_i   = 1'b0;
  endtask

  task automatic doClear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    // Reset state
    rst_i = 1'b1;
    tick();
    checkOutput("rst_valid", out_valid_o, 0);
    checkOutput("rst_ready", wr_ready_o, 1);
    checkOutput("rst_done", load_done_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_bias", out_bias_o, 0);
    checkOutput("rst_weight", out_weight_o, 0);
    rst_i = 1'b0;

    // Single packet
    out_ready_i = 1'b1;
    applyStimulus(1'b0, 32'h04030201);
    checkOutput("sp_valid_before_bias", out_valid_o, 0);
    applyStimulus(1'b1, 32'hFFFFFFF6);
    checkOutput("sp_valid", out_valid_o, 1);
    checkOutput("sp_weight", out_weight_o, 24'h030201);
    checkOutput("sp_input", out_input_o, 8'h04);
    checkOutput("sp_bias", out_bias_o, 32'hFFFFFFF6);
    checkOutput("sp_gate", out_gate_o, 0);
    checkOutput("sp_unit", out_unit_o, 0);
    checkOutput("sp_last", out_last_o, 0);
    tick();
    checkOutput("sp_popped", out_valid_o, 0);

    // Full load of 2 units x 4 gates
    doClear();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 32'h10203000 + i);
      applyStimulus(1'b1, 32'h100 + i);
      checkOutput($sformatf("fl_valid_%0d", i), out_valid_o, 1);
      checkOutput($sformatf("fl_bias_%0d", i), out_bias_o, 32'h100 + i);
      checkOutput($sformatf("fl_weight_%0d", i), out_weight_o, 24'h203000 + i);
      checkOutput($sformatf("fl_gate_%0d", i), out_gate_o, i % 4);
      checkOutput($sformatf("fl_unit_%0d", i), out_unit_o, i / 4);
      checkOutput($sformatf("fl_last_%0d", i), out_last_o, (i == 7) ? 1 : 0);
      checkOutput($sformatf("fl_done_%0d", i), load_done_o, (i == 7) ? 1 : 0);
    end
    checkOutput("fl_ready_blocked", wr_ready_o, 0);
    tick();
    checkOutput("fl_drained", out_valid_o, 0);
    checkOutput("fl_done_sticky", load_done_o, 1);

    // Protocol errors
    doClear();
    checkOutput("pe_done_cleared", load_done_o, 0);
    checkOutput("pe_err_clean", err_o, 0);
    applyStimulus(1'b1, 32'h00000099);
    checkOutput("pe_bias_first_err", err_o, 1);
    checkOutput("pe_bias_first_dropped", out_valid_o, 0);
    applyStimulus(1'b0, 32'h11223344);
    applyStimulus(1'b0, 32'h55667788);
    applyStimulus(1'b1, 32'h00000007);
    checkOutput("pe_valid", out_valid_o, 1);
    checkOutput("pe_weight_b", out_weight_o, 24'h667788);
    checkOutput("pe_input_b", out_input_o, 8'h55);
    checkOutput("pe_bias", out_bias_o, 32'h7);
    checkOutput("pe_gate", out_gate_o, 0);

    // Clear with 3 packets queued and a WI word held
    doClear();
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'hA0A0A000 + i);
      applyStimulus(1'b1, 32'h40 + i);
    end
    applyStimulus(1'b0, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'hCAFEF00D);
    checkOutput("cl_err_before", err_o, 1);
    checkOutput("cl_head_before", out_bias_o, 32'h40);
    clear_i      = 1'b1;
    out_ready_i  = 1'b1;
    applyStimulus(1'b1, 32'h00000055);
    clear_i      = 1'b0;
    checkOutput("cl_valid", out_valid_o, 0);
    checkOutput("cl_err", err_o, 0);
    checkOutput("cl_done", load_done_o, 0);
    checkOutput("cl_ready", wr_ready_o, 1);
    applyStimulus(1'b0, 32'h0A0B0C0D);
    applyStimulus(1'b1, 32'h00000022);
    checkOutput("cl_next_valid", out_valid_o, 1);
    checkOutput("cl_next_gate", out_gate_o, 0);
    checkOutput("cl_next_unit", out_unit_o, 0);
    checkOutput("cl_next_weight", out_weight_o, 24'h0B0C0D);
    checkOutput("cl_next_bias", out_bias_o, 32'h22);

    // Simultaneous push and pop at count 5
    doClear();
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h00000000 + i);
      applyStimulus(1'b1, 32'h200 + i);
    end
    applyStimulus(1'b0, 32'h00000005);
    out_ready_i = 1'b1;
    applyStimulus(1'b1, 32'h205);
    for (int k = 1; k <= 5; k++) begin
      checkOutput($sformatf("pp_valid_%0d", k), out_valid_o, 1);
      checkOutput($sformatf("pp_bias_%0d", k), out_bias_o, 32'h200 + k);
      checkOutput($sformatf("pp_gate_%0d", k), out_gate_o, k % 4);
      tick();
    end
    checkOutput("pp_empty", out_valid_o, 0);

    // Backpressure on the three-unit instance
    doClear();
    out_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 32'h00C0C000 + i);
      applyStimulus(1'b1, 32'h300 + i);
    end
    checkOutput("bp_ready_wi", b_wr_ready_o, 1);
    checkOutput("bp_done", b_load_done_o, 0);
    applyStimulus(1'b0, 32'h00C0C00A);
    checkOutput("bp_full_blocks", b_wr_ready_o, 0);
    checkOutput("bp_head", b_out_bias_o, 32'h300);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    checkOutput("bp_ready_after_pop", b_wr_ready_o, 1);
    applyStimulus(1'b1, 32'h30A);
    out_ready_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      checkOutput($sformatf("bp_valid_%0d", k), b_out_valid_o, 1);
      checkOutput($sformatf("bp_bias_%0d", k), b_out_bias_o, 32'h300 + k);
      checkOutput($sformatf("bp_gate_%0d", k), b_out_gate_o, k % 4);
      checkOutput($sformatf("bp_unit_%0d", k), b_out_unit_o, k / 4);
      tick();
    end
    checkOutput("bp_empty", b_out_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
